// File: rtl/spi_flash_slave_resp_if.sv
// SPI pin bundle between a flash controller (master) and the flash responder (slave).
interface spi_flash_slave_resp_if;
  logic spi_csn;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_csn, spi_sck, spi_mosi, input spi_miso, spi_miso_oe);
  modport slave  (input spi_csn, spi_sck, spi_mosi, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_flash_slave_resp.sv
// Oversampled SPI flash responder: decodes READ/PROG/RDID/RDSR/WREN/WRDI
// against an internal byte memory.
module spi_flash_slave_resp #(
  parameter bit          ACTIVE   = 1'b0,
  parameter bit          PHASE    = 1'b0,
  parameter int          AW       = 8,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic                  clock,
  input  logic                  rst,
  spi_flash_slave_resp_if.slave spi,
  output logic                  busy,
  output logic                  cmd_vld,
  output logic [7:0]            cmd_code,
  output logic                  cmd_err,
  output logic                  prog_vld,
  output logic [AW-1:0]         prog_addr,
  output logic [7:0]            prog_data,
  output logic                  wel
);
  localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, ADDR = 3'd2, READ = 3'd3,
                         PROG = 3'd4, ID = 3'd5, STAT = 3'd6, IGNORE = 3'd7;
  localparam logic [AW-1:0] PAGE = AW'(8'hFF);

  logic [1:0]    csn_s, mosi_s;
  logic          csn_d;
  logic [2:0]    sck_s;
  logic [2:0]    state, bitcnt;
  logic [7:0]    shreg, tx_sh, tx_buf, rx_byte, ld_byte;
  logic [AW-1:0] addr, addr_in;
  logic [1:0]    addr_cnt, id_idx;
  logic          to_read, prog_seen, ld;
  logic          sck_rise, sck_fall, sample, shift_e, byte_done;
  logic          csn_fall, csn_rise, prog_we;
  logic [7:0]    mem [2**AW];

  // csn sync resets low so a csn held low across reset never looks like a new frame
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      csn_s  <= 2'b00;
      csn_d  <= 1'b0;
      sck_s  <= {3{ACTIVE}};
      mosi_s <= 2'b00;
    end else begin
      csn_s  <= {csn_s[0], spi.spi_csn};
      csn_d  <= csn_s[1];
      sck_s  <= {sck_s[1:0], spi.spi_sck};
      mosi_s <= {mosi_s[0], spi.spi_mosi};
    end
  end

  assign csn_fall  = !csn_s[1] && csn_d;
  assign csn_rise  = csn_s[1] && !csn_d;
  assign sck_rise  = sck_s[1] && !sck_s[2];
  assign sck_fall  = !sck_s[1] && sck_s[2];
  assign sample    = (state != IDLE) && ((ACTIVE == PHASE) ? sck_rise : sck_fall);
  assign shift_e   = (state != IDLE) && ((ACTIVE == PHASE) ? sck_fall : sck_rise);
  assign rx_byte   = {shreg[6:0], mosi_s[1]};
  assign byte_done = sample && (bitcnt == 3'd7);
  assign addr_in   = AW'({addr, rx_byte});
  assign prog_we   = byte_done && (state == PROG) && wel;

  // Next tx byte, chosen at each completed byte
  always_comb begin
    ld      = 1'b0;
    ld_byte = 8'h00;
    if (byte_done) begin
      case (state)
        CMD: begin
          ld      = (rx_byte == 8'h9F) || (rx_byte == 8'h05);
          ld_byte = (rx_byte == 8'h9F) ? JEDEC_ID[23:16] : {6'b0, wel, 1'b0};
        end
        ADDR: begin
          ld      = to_read && (addr_cnt == 2'd2);
          ld_byte = mem[addr_in];
        end
        READ: begin
          ld      = 1'b1;
          ld_byte = mem[addr];
        end
        ID: begin
          ld = 1'b1;
          case (id_idx)
            2'd1:    ld_byte = JEDEC_ID[15:8];
            2'd2:    ld_byte = JEDEC_ID[7:0];
            default: ld_byte = 8'h00;
          endcase
        end
        STAT: begin
          ld      = 1'b1;
          ld_byte = {6'b0, wel, 1'b0};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= 3'd0;
      shreg     <= 8'h00;
      tx_sh     <= 8'h00;
      tx_buf    <= 8'h00;
      addr      <= '0;
      addr_cnt  <= 2'd0;
      id_idx    <= 2'd0;
      to_read   <= 1'b0;
      prog_seen <= 1'b0;
      cmd_vld   <= 1'b0;
      cmd_code  <= 8'h00;
      cmd_err   <= 1'b0;
      prog_vld  <= 1'b0;
      prog_addr <= '0;
      prog_data <= 8'h00;
      wel       <= 1'b0;
    end else begin
      cmd_vld  <= 1'b0;
      cmd_err  <= 1'b0;
      prog_vld <= 1'b0;
      if (sample) begin
        bitcnt <= bitcnt + 3'd1;
        shreg  <= rx_byte;
      end
      // bitcnt==0 marks the byte boundary: hold the freshly loaded MSB (PHASE=0)
      // or present it from tx_buf (PHASE=1)
      if (shift_e) begin
        if (bitcnt != 3'd0) tx_sh <= {tx_sh[6:0], 1'b0};
        else if (PHASE)     tx_sh <= tx_buf;
      end
      if (ld) begin
        tx_buf <= ld_byte;
        if (!PHASE) tx_sh <= ld_byte;
      end
      if (byte_done) begin
        case (state)
          CMD: begin
            cmd_vld  <= 1'b1;
            cmd_code <= rx_byte;
            addr_cnt <= 2'd0;
            case (rx_byte)
              8'h03:   begin state <= ADDR; to_read <= 1'b1; end
              8'h02:   begin state <= ADDR; to_read <= 1'b0; end
              8'h9F:   begin state <= ID; id_idx <= 2'd1; end
              8'h05:   state <= STAT;
              8'h06:   begin state <= IGNORE; wel <= 1'b1; end
              8'h04:   begin state <= IGNORE; wel <= 1'b0; end
              default: begin state <= IGNORE; cmd_err <= 1'b1; end
            endcase
          end
          ADDR: begin
            addr     <= addr_in;
            addr_cnt <= addr_cnt + 2'd1;
            if (addr_cnt == 2'd2) begin
              state <= to_read ? READ : PROG;
              if (to_read) addr <= addr_in + 1'b1;
            end
          end
          READ: addr <= addr + 1'b1;
          PROG: begin
            if (wel) begin
              prog_vld  <= 1'b1;
              prog_addr <= addr;
              prog_data <= rx_byte;
              prog_seen <= 1'b1;
            end
            addr <= (addr & ~PAGE) | ((addr + 1'b1) & PAGE);
          end
          ID: if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
          default: ;
        endcase
      end
      if (csn_fall) begin
        state     <= CMD;
        bitcnt    <= 3'd0;
        prog_seen <= 1'b0;
      end
      // a byte completing on the same cycle as csn rise is still written above
      if (csn_rise) begin
        state  <= IDLE;
        bitcnt <= 3'd0;
        if (prog_seen || prog_we) wel <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock)
    if (prog_we) mem[addr] <= rx_byte;

  assign busy            = (state != IDLE);
  assign spi.spi_miso_oe = (state == READ) || (state == ID) || (state == STAT);
  assign spi.spi_miso    = spi.spi_miso_oe & tx_sh[7];
endmodule
